// File: rtl/combo_scorer.sv
// combo_scorer: combo / multiplier / score / best-score tracking for the play
// states, plus a sequential double-dabble converter driving the BCD readout.
module combo_scorer #(
    parameter int BASE_PTS   = 10,
    parameter int COMBO_STEP = 8,
    parameter int MULT_MAX   = 4,
    parameter int SCORE_MAX  = 9999,
    parameter int COMBO_MAX  = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic        hit_0,
    input  logic        hit_1,
    input  logic        hit_2,
    input  logic        damage_0,
    input  logic        damage_1,
    input  logic        damage_2,
    output logic [6:0]  combo,
    output logic [2:0]  mult,
    output logic [13:0] score,
    output logic [13:0] best,
    output logic        new_best,
    output logic [15:0] score_bcd,
    output logic        bcd_valid
);

    localparam logic [14:0] BASE_PTS_L   = 15'(BASE_PTS);
    localparam logic [14:0] SCORE_MAX_L  = 15'(SCORE_MAX);
    localparam logic [7:0]  COMBO_MAX_L  = 8'(COMBO_MAX);
    localparam logic [6:0]  COMBO_STEP_L = 7'(COMBO_STEP);
    localparam logic [6:0]  STEP_CAP_L   = 7'(MULT_MAX - 1);
    localparam logic [2:0]  MULT_MAX_L   = 3'(MULT_MAX);
    localparam logic [3:0]  LAST_SHIFT_L = 4'd13;   // 14 iterations: 0..13

    typedef enum logic [1:0] {
        BCD_IDLE,
        BCD_LOAD,
        BCD_SHIFT,
        BCD_DONE
    } bcd_state_t;

    logic        play;
    logic        play_q;
    logic [6:0]  combo_q,     combo_d;
    logic [2:0]  mult_q,      mult_d;
    logic [13:0] score_q,     score_d;
    logic [13:0] best_q,      best_d;
    logic        new_best_q,  new_best_d;

    bcd_state_t  bcd_state_q, bcd_state_d;
    logic [3:0]  shift_cnt_q, shift_cnt_d;
    logic [29:0] dd_q,        dd_d;        // {bcd[15:0], bin[13:0]}
    logic [15:0] score_bcd_q, score_bcd_d;
    logic        bcd_valid_q, bcd_valid_d;

    logic [1:0]  nh;
    logic        any_miss;
    logic [14:0] add_pts;
    logic [14:0] score_sum;
    logic [7:0]  combo_sum;
    logic [6:0]  mult_step;

    assign play     = (state == 4'd1) || (state == 4'd2) || (state == 4'd3);
    assign nh       = 2'(hit_0) + 2'(hit_1) + 2'(hit_2);
    assign any_miss = damage_0 | damage_1 | damage_2;

    // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift.
    function automatic logic [29:0] dabble(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[14 + 4*i +: 4] >= 4'd5) begin
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

    // Scoring next-state: round start clear, in-play update, round-end best capture.
    always_comb begin
        combo_d    = combo_q;
        mult_d     = mult_q;
        score_d    = score_q;
        best_d     = best_q;
        new_best_d = 1'b0;
        add_pts    = 15'(nh) * 15'(mult_q) * BASE_PTS_L;
        score_sum  = {1'b0, score_q} + add_pts;
        combo_sum  = {1'b0, combo_q} + 8'(nh);
        mult_step  = 7'd0;

        if (play && !play_q) begin
            // First play cycle of a round: clear, this cycle's pulses are dropped.
            combo_d = 7'd0;
            mult_d  = 3'd1;
            score_d = 14'd0;
        end else if (play) begin
            // Scoring uses the multiplier in force before this cycle's update.
            score_d = (score_sum > SCORE_MAX_L) ? SCORE_MAX_L[13:0] : score_sum[13:0];
            if (any_miss) begin
                combo_d = 7'd0;
            end else begin
                combo_d = (combo_sum > COMBO_MAX_L) ? COMBO_MAX_L[6:0] : combo_sum[6:0];
            end
            mult_step = combo_d / COMBO_STEP_L;
            mult_d    = (mult_step >= STEP_CAP_L) ? MULT_MAX_L : (3'(mult_step) + 3'd1);
        end else if (play_q) begin
            // Strictly greater: a tie with the best keeps the pulse low.
            if (score_q > best_q) begin
                best_d     = score_q;
                new_best_d = 1'b1;
            end
        end
    end

    // BCD converter next-state; any score change restarts the conversion.
    always_comb begin
        bcd_state_d = bcd_state_q;
        shift_cnt_d = shift_cnt_q;
        dd_d        = dd_q;
        score_bcd_d = score_bcd_q;
        bcd_valid_d = bcd_valid_q;

        case (bcd_state_q)
            BCD_IDLE: ;
            BCD_LOAD: begin
                dd_d        = {16'd0, score_q};
                shift_cnt_d = 4'd0;
                bcd_state_d = BCD_SHIFT;
            end
            BCD_SHIFT: begin
                dd_d        = dabble(dd_q);
                shift_cnt_d = shift_cnt_q + 4'd1;
                if (shift_cnt_q == LAST_SHIFT_L) begin
                    bcd_state_d = BCD_DONE;
                end
            end
            BCD_DONE: begin
                score_bcd_d = dd_q[29:16-2];
                bcd_valid_d = 1'b1;
                bcd_state_d = BCD_IDLE;
            end
            default: bcd_state_d = BCD_IDLE;
        endcase

        if (score_d != score_q) begin
            // Abort wins over a same-cycle DONE so the readout never shows a stale result.
            bcd_state_d = BCD_LOAD;
            bcd_valid_d = 1'b0;
            score_bcd_d = score_bcd_q;
        end
    end

    // State registers for scoring and the converter.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            play_q      <= 1'b0;
            combo_q     <= 7'd0;
            mult_q      <= 3'd1;
            score_q     <= 14'd0;
            best_q      <= 14'd0;
            new_best_q  <= 1'b0;
            bcd_state_q <= BCD_IDLE;
            shift_cnt_q <= 4'd0;
            dd_q        <= 30'd0;
            score_bcd_q <= 16'd0;
            bcd_valid_q <= 1'b1;
        end else begin
            play_q      <= play;
            combo_q     <= combo_d;
            mult_q      <= mult_d;
            score_q     <= score_d;
            best_q      <= best_d;
            new_best_q  <= new_best_d;
            bcd_state_q <= bcd_state_d;
            shift_cnt_q <= shift_cnt_d;
            dd_q        <= dd_d;
            score_bcd_q <= score_bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign combo     = combo_q;
    assign mult      = mult_q;
    assign score     = score_q;
    assign best      = best_q;
    assign new_best  = new_best_q;
    assign score_bcd = score_bcd_q;
    assign bcd_valid = bcd_valid_q;

endmodule
